// File: rtl/mac_tree_engine.sv
`default_nettype none
// ============================================================================
//  Module      : mac_tree_engine
//  Description : Streaming unsigned dot-product engine. Operand beats of
//                LANES pairs are multiplied lane-wise into a product
//                register, reduced by a combinational adder tree and
//                accumulated across VEC_LEN/LANES beats. The result and
//                the RUN+DRAIN cycle count are offered on a valid/ready
//                output port.
//  Options     : `define MAC_TREE_SAT_EN -> accumulator saturates at
//                2^ACC_W-1 instead of wrapping (ovf is sticky either way).
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_tree_engine #(
    parameter int DATA_W  = 8,
    parameter int LANES   = 8,
    parameter int VEC_LEN = 64,
    parameter int ACC_W   = 24,
    parameter int CNT_W   = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] a_data,
    input  logic [LANES*DATA_W-1:0] b_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_sum,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf,
    output logic [CNT_W-1:0]        cycle_count
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int c_BEATS  = VEC_LEN / LANES;
    localparam int c_BEAT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_PROD_W = 2 * DATA_W;
    localparam int c_LVL    = $clog2(LANES);
    localparam int c_TREE_W = c_PROD_W + c_LVL;
    // One bit wider than the larger addend so the carry-out is visible.
    localparam int c_SUM_W  = ((ACC_W > c_TREE_W) ? ACC_W : c_TREE_W) + 1;

    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_BEATS - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_RUN   = 2'd1;
    localparam logic [1:0] c_S_DRAIN = 2'd2;
    localparam logic [1:0] c_S_OUT   = 2'd3;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_BEAT_W-1:0] r_beat;
    logic [ACC_W-1:0]    r_acc;
    logic                r_ovf;
    logic [CNT_W-1:0]    r_cycles;
    logic                r_done;

    logic [c_PROD_W-1:0] w_prod [LANES];
    logic [c_PROD_W-1:0] r_prod [LANES];
    logic [c_TREE_W-1:0] w_tree_sum;
    logic [c_SUM_W-1:0]  w_sum_full;
    logic                w_carry;
    logic [ACC_W-1:0]    w_acc_add;

    logic w_xfer;
    logic w_start_go;
    logic w_active;

    assign w_xfer     = in_valid & in_ready;
    assign w_start_go = (r_state == c_S_IDLE) & start;
    assign w_active   = (r_state == c_S_RUN) | (r_state == c_S_DRAIN);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // State register; reset aborts any run in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  if (start) w_state_nxt = c_S_RUN;
            c_S_RUN:   if (w_xfer && (r_beat == c_LAST_BEAT)) w_state_nxt = c_S_DRAIN;
            c_S_DRAIN: w_state_nxt = c_S_OUT;
            c_S_OUT:   if (out_ready) w_state_nxt = c_S_IDLE;
            default:   w_state_nxt = c_S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        in_ready  = (r_state == c_S_RUN);
        out_valid = (r_state == c_S_OUT);
        busy      = (r_state != c_S_IDLE);
    end

    // Beat counter: counts accepted beats within a run.
    always_ff @(posedge clock) begin
        if (reset || w_start_go) begin
            r_beat <= '0;
        end else if ((r_state == c_S_RUN) && w_xfer) begin
            r_beat <= r_beat + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Multipliers and product register
    // ------------------------------------------------------------------
    for (genvar i = 0; i < LANES; i++) begin : g_mul
        assign w_prod[i] = c_PROD_W'(a_data[i*DATA_W +: DATA_W])
                         * c_PROD_W'(b_data[i*DATA_W +: DATA_W]);
    end

    // Products captured only on a transfer; zero otherwise so stalls add nothing.
    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (reset || !w_xfer) begin
                r_prod[i] <= '0;
            end else begin
                r_prod[i] <= w_prod[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Adder tree: level 0 holds the products, each level halves the count.
    // ------------------------------------------------------------------
    for (genvar l = 0; l <= c_LVL; l++) begin : g_lvl
        localparam int c_N = LANES >> l;
        logic [c_TREE_W-1:0] w_node [c_N];
        if (l == 0) begin : g_leaf
            for (genvar j = 0; j < c_N; j++) begin : g_in
                assign w_node[j] = c_TREE_W'(r_prod[j]);
            end
        end else begin : g_add
            for (genvar j = 0; j < c_N; j++) begin : g_pair
                assign w_node[j] = g_lvl[l-1].w_node[2*j] + g_lvl[l-1].w_node[2*j+1];
            end
        end
    end

    assign w_tree_sum = g_lvl[c_LVL].w_node[0];

    // ------------------------------------------------------------------
    // Accumulator
    // ------------------------------------------------------------------
    assign w_sum_full = c_SUM_W'(r_acc) + c_SUM_W'(w_tree_sum);
    assign w_carry    = |w_sum_full[c_SUM_W-1:ACC_W];

`ifdef MAC_TREE_SAT_EN
    // Clamp at full scale; further additions re-clamp, so it stays there.
    assign w_acc_add = w_carry ? {ACC_W{1'b1}} : w_sum_full[ACC_W-1:0];
`else
    // Plain modulo-2^ACC_W wrap.
    assign w_acc_add = w_sum_full[ACC_W-1:0];
`endif

    // Accumulate the tree sum during RUN and DRAIN; cleared on start.
    always_ff @(posedge clock) begin
        if (reset || w_start_go) begin
            r_acc <= '0;
        end else if (w_active) begin
            r_acc <= w_acc_add;
        end
    end

    // Sticky overflow flag, cleared only by start or reset.
    always_ff @(posedge clock) begin
        if (reset || w_start_go) begin
            r_ovf <= 1'b0;
        end else if (w_active && w_carry) begin
            r_ovf <= 1'b1;
        end
    end

    // Cycle counter: runs in RUN and DRAIN, held otherwise until next start.
    always_ff @(posedge clock) begin
        if (reset || w_start_go) begin
            r_cycles <= '0;
        end else if (w_active) begin
            r_cycles <= r_cycles + 1'b1;
        end
    end

    // Done pulses for the cycle after the output handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == c_S_OUT) && out_ready;
        end
    end

    assign out_sum     = r_acc;
    assign ovf         = r_ovf;
    assign cycle_count = r_cycles;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mac_tree_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_tree_engine
//  Description : Directed bench for mac_tree_engine. Two instances share the
//                stimulus: defaults (ACC_W=24) and a narrow ACC_W=16 copy
//                that exercises overflow. Vector table plus hand sequences
//                for backpressure, ignored start and mid-run reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_tree_engine;

    localparam int c_DW    = 8;
    localparam int c_LANES = 8;
    localparam int c_BEATS = 8;

`ifdef MAC_TREE_SAT_EN
    localparam int c_EXP16_FULL = 32'hFFFF;
`else
    localparam int c_EXP16_FULL = 32'h8040;
`endif

    typedef struct {
        int mode;        // 0 uniform, 1 a=lane, 2 a=beat+1, 3 a=b=lane
        int a_val;
        int b_val;
        int stall_beat;  // -1 = no stall
        int stall_len;
        int exp_sum;
        int exp_cnt;
        int exp_sum16;
        int exp_ovf16;
    } vec_t;

    logic                      clock;
    logic                      reset;
    logic                      start;
    logic                      in_valid;
    logic [c_LANES*c_DW-1:0]   a_data;
    logic [c_LANES*c_DW-1:0]   b_data;
    logic                      out_ready;

    logic        in_ready, out_valid, busy, done, ovf;
    logic [23:0] out_sum;
    logic [15:0] cycle_count;

    logic        in_ready16, out_valid16, busy16, done16, ovf16;
    logic [15:0] out_sum16;
    logic [15:0] cycle_count16;

    int n_vec;
    int n_err;

    mac_tree_engine #(
        .DATA_W(8), .LANES(8), .VEC_LEN(64), .ACC_W(24), .CNT_W(16)
    ) u_dut (
        .clock(clock), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_data(a_data), .b_data(b_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .busy(busy), .done(done), .ovf(ovf), .cycle_count(cycle_count)
    );

    mac_tree_engine #(
        .DATA_W(8), .LANES(8), .VEC_LEN(64), .ACC_W(16), .CNT_W(16)
    ) u_dut16 (
        .clock(clock), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready16),
        .a_data(a_data), .b_data(b_data),
        .out_valid(out_valid16), .out_ready(out_ready), .out_sum(out_sum16),
        .busy(busy16), .done(done16), .ovf(ovf16), .cycle_count(cycle_count16)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge and settle outputs away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [c_LANES*c_DW-1:0] lane_word(input int mode, input int val,
                                                          input int beat, input bit is_a);
        logic [c_LANES*c_DW-1:0] w;
        int e;
        w = '0;
        for (int i = 0; i < c_LANES; i++) begin
            case (mode)
                1:       e = is_a ? i : val;
                2:       e = is_a ? beat + 1 : val;
                3:       e = i;
                default: e = val;
            endcase
            w[i*c_DW +: c_DW] = c_DW'(e);
        end
        return w;
    endfunction

    // Start a run and stream all beats, inserting the vector's stall.
    task automatic feed(input vec_t v);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int beat = 0; beat < c_BEATS; beat++) begin
            in_valid = 1'b1;
            a_data   = lane_word(v.mode, v.a_val, beat, 1'b1);
            b_data   = lane_word(v.mode, v.b_val, beat, 1'b0);
            tick();
            if (beat == v.stall_beat) begin
                // Garbage on the bus while in_valid is low must not count.
                in_valid = 1'b0;
                a_data   = '1;
                b_data   = '1;
                repeat (v.stall_len) tick();
            end
        end
        in_valid = 1'b0;
        a_data   = '1;
        b_data   = '1;
    endtask

    task automatic wait_out(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check({name, " out_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        feed(v);
        wait_out(name);
        check({name, " sum"},     32'(out_sum),       32'(v.exp_sum));
        check({name, " cnt"},     32'(cycle_count),   32'(v.exp_cnt));
        check({name, " ovf"},     32'(ovf),           32'd0);
        check({name, " sum16"},   32'(out_sum16),     32'(v.exp_sum16));
        check({name, " ovf16"},   32'(ovf16),         32'(v.exp_ovf16));
        check({name, " valid16"}, 32'(out_valid16),   32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, " done"},    32'(done),          32'd1);
        check({name, " valid_lo"},32'(out_valid),     32'd0);
        tick();
        check({name, " done_lo"}, 32'(done),          32'd0);
        check({name, " cnt_hold"},32'(cycle_count),   32'(v.exp_cnt));
    endtask

    initial begin
        vec_t vecs[6];
        vec_t ones;
        vecs[0] = '{0,   1,   1, -1, 0,      64,  9,   64, 0};
        vecs[1] = '{0, 255, 255, -1, 0, 4161600,  9, c_EXP16_FULL, 1};
        vecs[2] = '{1,   0,   1,  4, 3,     224, 12,  224, 0};
        vecs[3] = '{0,   2,   3, -1, 0,     384,  9,  384, 0};
        vecs[4] = '{2,   0,   1, -1, 0,     288,  9,  288, 0};
        vecs[5] = '{3,   0,   0,  0, 1,    1120, 10, 1120, 0};
        ones    = vecs[0];

        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_data    = '0;
        b_data    = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check("rst in_ready",  32'(in_ready),    32'd0);
        check("rst out_valid", 32'(out_valid),   32'd0);
        check("rst out_sum",   32'(out_sum),     32'd0);
        check("rst busy",      32'(busy),        32'd0);
        check("rst done",      32'(done),        32'd0);
        check("rst ovf",       32'(ovf),         32'd0);
        check("rst cnt",       32'(cycle_count), 32'd0);
        check("rst busy16",    32'(busy16),      32'd0);
        check("rst ready16",   32'(in_ready16),  32'd0);
        check("rst done16",    32'(done16),      32'd0);
        check("rst cnt16",     32'(cycle_count16), 32'd0);

        // Table of directed vectors
        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
        end

        // Output backpressure with a start pulse that must be ignored
        feed(ones);
        wait_out("bp");
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp valid%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("bp sum%0d", k),   32'(out_sum),   32'd64);
            check($sformatf("bp done%0d", k),  32'(done),      32'd0);
            start = (k == 2);
            tick();
        end
        start = 1'b0;
        check("bp cnt frozen", 32'(cycle_count), 32'd9);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp done",  32'(done), 32'd1);
        tick();
        check("bp idle",  32'(busy), 32'd0);
        check("bp done_lo", 32'(done), 32'd0);

        // Reset during beat 3 of a run
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int beat = 0; beat < 3; beat++) begin
            in_valid = 1'b1;
            a_data   = lane_word(0, 1, beat, 1'b1);
            b_data   = lane_word(0, 1, beat, 1'b0);
            tick();
        end
        check("mid busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        check("mr busy",      32'(busy),        32'd0);
        check("mr in_ready",  32'(in_ready),    32'd0);
        check("mr out_valid", 32'(out_valid),   32'd0);
        check("mr out_sum",   32'(out_sum),     32'd0);
        check("mr cnt",       32'(cycle_count), 32'd0);
        check("mr done",      32'(done),        32'd0);
        check("mr ovf",       32'(ovf),         32'd0);
        repeat (2) tick();
        check("mr stays idle", 32'(busy), 32'd0);
        run_vec(ones, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
